// File: rtl/lsu_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// lsu_pkg : access sizes, FSM states and lane constants for lsu_bus_master
// Revision: 1.0
// ----------------------------------------------------------------------------
package lsu_pkg;

  typedef enum logic [1:0] {
    BYTE     = 2'd0,
    HALF     = 2'd1,
    WORD     = 2'd2,
    SIZE_ILL = 2'd3
  } size_e;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    RD      = 3'd2,
    RD_WAIT = 3'd3,
    RMW_WR  = 3'd4,
    RESP    = 3'd5
  } lsu_state_e;

  localparam int LSU_TIMEOUT_DEF = 16;

  localparam logic [3:0] LANE_BYTE = 4'b0001;
  localparam logic [3:0] LANE_HALF = 4'b0011;
  localparam logic [3:0] LANE_WORD = 4'b1111;

  function automatic logic [31:0] lanes_to_bits(input logic [3:0] lanes);
    return {{8{lanes[3]}}, {8{lanes[2]}}, {8{lanes[1]}}, {8{lanes[0]}}};
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_lane_align.sv
`default_nettype none
// ----------------------------------------------------------------------------
// lsu_lane_align : byte-lane strobes, store replication, load extract and RMW merge
// Revision: 1.0
// ----------------------------------------------------------------------------
module lsu_lane_align
  import lsu_pkg::*;
(
  input  size_e       size,
  input  logic [1:0]  offset,
  input  logic        sgn,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  strobe,
  output logic [31:0] wdata_rep,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [31:0] shifted;

  always_comb begin
    shifted   = rdata >> {offset, 3'b000};
    strobe    = LANE_WORD;
    wdata_rep = wdata;
    load_data = shifted;
    case (size)
      BYTE: begin
        strobe    = LANE_BYTE << offset;
        wdata_rep = {4{wdata[7:0]}};
        load_data = {{24{sgn & shifted[7]}}, shifted[7:0]};
      end
      HALF: begin
        strobe    = LANE_HALF << offset;
        wdata_rep = {2{wdata[15:0]}};
        load_data = {{16{sgn & shifted[15]}}, shifted[15:0]};
      end
      default: ;
    endcase
    // new lanes come from the replicated store data, the rest from the read word
    merged = (rdata & ~lanes_to_bits(strobe)) | (wdata_rep & lanes_to_bits(strobe));
  end

endmodule
`default_nettype wire

// File: rtl/lsu_bus_master.sv
`default_nettype none
// ----------------------------------------------------------------------------
// lsu_bus_master : single-outstanding load/store initiator on the ic0 data bus
// Option macro LSU_RMW_EN: sub-word stores run as read-modify-write.
// Revision: 1.0
// ----------------------------------------------------------------------------
module lsu_bus_master
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = LSU_TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        ic0_c_axi_mst_wr_valid,
  output logic        ic0_c_axi_mst_rd_valid,
  output logic [31:0] ic0_axi_mst_wr_addr,
  output logic [31:0] ic0_axi_mst_rd_addr,
  output logic [31:0] ic0_axi_mst_wr_data,
  output logic [3:0]  ic0_axi_mst_wr_strobe,
  input  logic        ic0_c_axi_slv_rd_ready_1,
  input  logic [31:0] ic0_axi_slv_rd_data_1
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
`ifdef LSU_RMW_EN
  localparam bit RMW_EN = 1'b1;
`else
  localparam bit RMW_EN = 1'b0;
`endif

  lsu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             we_q, we_d;
  size_e            size_q, size_d;
  logic             sgn_q, sgn_d;
  logic [1:0]       off_q, off_d;
  logic [31:0]      wdata_q, wdata_d;

  logic             req_ready_q, req_ready_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [31:0]      rsp_rdata_q, rsp_rdata_d;
  logic             rsp_err_q, rsp_err_d;
  logic             wr_valid_q, wr_valid_d;
  logic             rd_valid_q, rd_valid_d;
  logic [31:0]      wr_addr_q, wr_addr_d;
  logic [31:0]      rd_addr_q, rd_addr_d;
  logic [31:0]      wr_data_q, wr_data_d;
  logic [3:0]       wr_strobe_q, wr_strobe_d;

  size_e            size_in;
  logic             idle;
  logic             req_bad;
  size_e            al_size;
  logic [1:0]       al_off;
  logic             al_sgn;
  logic [31:0]      al_wdata;
  logic [3:0]       al_strobe;
  logic [31:0]      al_wdata_rep;
  logic [31:0]      al_load;
  logic [31:0]      al_merged;

  assign size_in = size_e'(req_size);
  assign idle    = (state_q == IDLE);

  // the aligner sees the live request in IDLE and the captured one afterwards
  assign al_size  = idle ? size_in        : size_q;
  assign al_off   = idle ? req_addr[1:0]  : off_q;
  assign al_sgn   = idle ? req_signed     : sgn_q;
  assign al_wdata = idle ? req_wdata      : wdata_q;

  lsu_lane_align u_align (
    .size      (al_size),
    .offset    (al_off),
    .sgn       (al_sgn),
    .wdata     (al_wdata),
    .rdata     (ic0_axi_slv_rd_data_1),
    .strobe    (al_strobe),
    .wdata_rep (al_wdata_rep),
    .load_data (al_load),
    .merged    (al_merged)
  );

  always_comb begin
    req_bad = 1'b0;
    case (size_in)
      HALF:     req_bad = req_addr[0];
      WORD:     req_bad = |req_addr[1:0];
      SIZE_ILL: req_bad = 1'b1;
      default:  ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    size_d      = size_q;
    sgn_d       = sgn_q;
    off_d       = off_q;
    wdata_d     = wdata_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
    wr_valid_d  = 1'b0;
    rd_valid_d  = 1'b0;
    wr_addr_d   = wr_addr_q;
    rd_addr_d   = rd_addr_q;
    wr_data_d   = wr_data_q;
    wr_strobe_d = wr_strobe_q;
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          we_d        = req_we;
          size_d      = size_in;
          sgn_d       = req_signed;
          off_d       = req_addr[1:0];
          wdata_d     = req_wdata;
          req_ready_d = 1'b0;
          if (req_bad) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else if (req_we && !(RMW_EN && size_in != WORD)) begin
            state_d     = WR;
            wr_valid_d  = 1'b1;
            wr_addr_d   = {2'b00, req_addr[31:2]};
            wr_data_d   = al_wdata_rep;
            wr_strobe_d = al_strobe;
          end else begin
            state_d    = RD;
            rd_valid_d = 1'b1;
            rd_addr_d  = {2'b00, req_addr[31:2]};
          end
        end
      end
      WR, RMW_WR: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
      end
      RD: begin
        state_d = RD_WAIT;
        cnt_d   = '0;
      end
      RD_WAIT: begin
        if (ic0_c_axi_slv_rd_ready_1) begin
          if (we_q) begin
            state_d     = RMW_WR;
            wr_valid_d  = 1'b1;
            wr_addr_d   = rd_addr_q;
            wr_data_d   = al_merged;
            wr_strobe_d = LANE_WORD;
          end else begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = al_load;
          end
        end else if (cnt_q == CNT_W'(TIMEOUT)) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      size_q      <= BYTE;
      sgn_q       <= 1'b0;
      off_q       <= 2'b00;
      wdata_q     <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      wr_valid_q  <= 1'b0;
      rd_valid_q  <= 1'b0;
      wr_addr_q   <= '0;
      rd_addr_q   <= '0;
      wr_data_q   <= '0;
      wr_strobe_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      size_q      <= size_d;
      sgn_q       <= sgn_d;
      off_q       <= off_d;
      wdata_q     <= wdata_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      wr_valid_q  <= wr_valid_d;
      rd_valid_q  <= rd_valid_d;
      wr_addr_q   <= wr_addr_d;
      rd_addr_q   <= rd_addr_d;
      wr_data_q   <= wr_data_d;
      wr_strobe_q <= wr_strobe_d;
    end
  end

  assign req_ready              = req_ready_q;
  assign rsp_valid              = rsp_valid_q;
  assign rsp_rdata              = rsp_rdata_q;
  assign rsp_err                = rsp_err_q;
  assign ic0_c_axi_mst_wr_valid = wr_valid_q;
  assign ic0_c_axi_mst_rd_valid = rd_valid_q;
  assign ic0_axi_mst_wr_addr    = wr_addr_q;
  assign ic0_axi_mst_rd_addr    = rd_addr_q;
  assign ic0_axi_mst_wr_data    = wr_data_q;
  assign ic0_axi_mst_wr_strobe  = wr_strobe_q;

endmodule
`default_nettype wire

// File: tb/tb_lsu_bus_master.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_lsu_bus_master : directed and randomized checks against a behavioural model
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_lsu_bus_master;

  localparam int TMO = 16;
`ifdef LSU_RMW_EN
  localparam bit RMW = 1'b1;
`else
  localparam bit RMW = 1'b0;
`endif

  logic        clk, rst_n;
  logic        req_valid, req_ready, req_we, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mst_wr_valid, mst_rd_valid;
  logic [31:0] wr_addr, rd_addr, wr_data;
  logic [3:0]  wr_strobe;
  logic        slv_ready;
  logic [31:0] slv_data;

  int errors, checks;

  logic [31:0] mem     [0:255];
  logic [31:0] ref_mem [0:255];

  int          o_wr_cnt, o_wr_cyc, o_rd_cnt, o_rd_cyc, o_rsp_cnt, o_rsp_cyc, o_rdy_cyc;
  logic [31:0] o_wr_addr, o_wr_data, o_rd_addr, o_rsp_rdata;
  logic [3:0]  o_wr_strb;
  logic        o_rsp_err;

  int          e_wr_cnt, e_wr_cyc, e_rd_cnt, e_rsp_cyc;
  logic [31:0] e_wr_data, e_rdata;
  logic [3:0]  e_wr_strb;
  logic        e_err;

  lsu_bus_master #(.TIMEOUT(TMO)) dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .req_valid                (req_valid),
    .req_ready                (req_ready),
    .req_we                   (req_we),
    .req_size                 (req_size),
    .req_signed               (req_signed),
    .req_addr                 (req_addr),
    .req_wdata                (req_wdata),
    .rsp_valid                (rsp_valid),
    .rsp_rdata                (rsp_rdata),
    .rsp_err                  (rsp_err),
    .ic0_c_axi_mst_wr_valid   (mst_wr_valid),
    .ic0_c_axi_mst_rd_valid   (mst_rd_valid),
    .ic0_axi_mst_wr_addr      (wr_addr),
    .ic0_axi_mst_rd_addr      (rd_addr),
    .ic0_axi_mst_wr_data      (wr_data),
    .ic0_axi_mst_wr_strobe    (wr_strobe),
    .ic0_c_axi_slv_rd_ready_1 (slv_ready),
    .ic0_axi_slv_rd_data_1    (slv_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected behaviour of one request, derived from the access rules alone.
  task automatic predict(input bit we, input logic [1:0] sz, input bit sgn,
                         input logic [31:0] addr, input logic [31:0] wd, input int lat);
    int          off, nbytes;
    bit          bad;
    logic [7:0]  idx;
    logic [31:0] v;
    logic [3:0]  lanes;
    off    = int'(addr[1:0]);
    nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    bad    = (sz == 2'd3) || (off % nbytes != 0);
    idx    = addr[9:2];
    lanes  = 4'((1 << nbytes) - 1);
    lanes  = lanes << off;
    e_wr_cnt = 0; e_rd_cnt = 0; e_wr_cyc = -1; e_err = 1'b0;
    e_rdata = '0; e_wr_data = '0; e_wr_strb = '0;
    if (bad) begin
      e_rsp_cyc = 1; e_err = 1'b1;
    end else if (we && !(RMW && nbytes < 4)) begin
      e_wr_cnt = 1; e_wr_cyc = 1; e_rsp_cyc = 2; e_wr_strb = lanes;
      e_wr_data = (nbytes == 1) ? {4{wd[7:0]}} : (nbytes == 2) ? {2{wd[15:0]}} : wd;
      for (int b = 0; b < nbytes; b++) ref_mem[idx][8*(off+b) +: 8] = wd[8*b +: 8];
    end else begin
      e_rd_cnt = 1;
      if (lat == 0) begin
        e_rsp_cyc = TMO + 3; e_err = 1'b1;
      end else if (!we) begin
        e_rsp_cyc = 2 + lat;
        v = ref_mem[idx] >> (8 * off);
        if (nbytes == 1)      e_rdata = sgn ? 32'($signed(v[7:0]))  : 32'(v[7:0]);
        else if (nbytes == 2) e_rdata = sgn ? 32'($signed(v[15:0])) : 32'(v[15:0]);
        else                  e_rdata = v;
      end else begin
        e_wr_cnt = 1; e_wr_cyc = 2 + lat; e_rsp_cyc = 3 + lat; e_wr_strb = 4'hF;
        v = ref_mem[idx];
        for (int b = 0; b < nbytes; b++) v[8*(off+b) +: 8] = wd[8*b +: 8];
        e_wr_data = v;
        ref_mem[idx] = v;
      end
    end
  endtask

  // Drives one request, acts as the memory slave and records what the bus did.
  task automatic do_txn(input bit we, input logic [1:0] sz, input bit sgn,
                        input logic [31:0] addr, input logic [31:0] wd, input int lat);
    int rd_at;
    bit done;
    o_wr_cnt = 0; o_rd_cnt = 0; o_rsp_cnt = 0;
    o_wr_cyc = -1; o_rd_cyc = -1; o_rsp_cyc = -1; o_rdy_cyc = -1;
    o_wr_addr = '0; o_wr_data = '0; o_wr_strb = '0; o_rd_addr = '0;
    o_rsp_rdata = '0; o_rsp_err = 1'b0;
    rd_at = -1; done = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sgn;
    req_addr = addr; req_wdata = wd;
    @(posedge clk);
    for (int k = 1; k <= 48 && !done; k++) begin
      @(negedge clk);
      req_valid = 1'b0; req_wdata = $urandom; req_addr = $urandom;
      if (mst_wr_valid) begin
        o_wr_cnt++; o_wr_cyc = k; o_wr_addr = wr_addr; o_wr_data = wr_data; o_wr_strb = wr_strobe;
        for (int b = 0; b < 4; b++)
          if (wr_strobe[b]) mem[wr_addr[7:0]][8*b +: 8] = wr_data[8*b +: 8];
      end
      if (mst_rd_valid) begin
        o_rd_cnt++; o_rd_cyc = k; o_rd_addr = rd_addr; rd_at = k;
      end
      if (rsp_valid) begin
        o_rsp_cnt++; o_rsp_cyc = k; o_rsp_rdata = rsp_rdata; o_rsp_err = rsp_err;
      end
      if (req_ready) begin
        o_rdy_cyc = k; done = 1'b1;
      end
      if (lat > 0 && rd_at > 0 && k == rd_at + lat) begin
        slv_ready = 1'b1; slv_data = mem[o_rd_addr[7:0]];
      end else begin
        slv_ready = 1'b0; slv_data = $urandom;
      end
    end
    slv_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0; slv_ready = 1'b0; slv_data = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset req_ready got=%b exp=1", req_ready); end
    checks++; if ({rsp_valid, rsp_err, mst_wr_valid, mst_rd_valid} !== 4'b0) begin
      errors++; $display("FAIL reset pulses got=%b exp=0000", {rsp_valid, rsp_err, mst_wr_valid, mst_rd_valid}); end
    checks++; if ({wr_addr, rd_addr, wr_data, rsp_rdata} !== 128'b0) begin
      errors++; $display("FAIL reset buses got=%h exp=0", {wr_addr, rd_addr, wr_data, rsp_rdata}); end
    checks++; if (wr_strobe !== 4'b0) begin errors++; $display("FAIL reset wr_strobe got=%b exp=0000", wr_strobe); end
  endtask

  task automatic test_store_byte();
    predict(1'b1, 2'd0, 1'b0, 32'h103, 32'h0000_00A5, 1);
    do_txn(1'b1, 2'd0, 1'b0, 32'h103, 32'h0000_00A5, 1);
    checks++; if (o_wr_addr !== 32'h40) begin errors++; $display("FAIL store_byte wr_addr got=%h exp=40", o_wr_addr); end
    checks++; if (o_rsp_err !== 1'b0) begin errors++; $display("FAIL store_byte rsp_err got=%b exp=0", o_rsp_err); end
    checks++; if (o_rsp_cnt != 1) begin errors++; $display("FAIL store_byte rsp_count got=%0d exp=1", o_rsp_cnt); end
`ifdef LSU_RMW_EN
    checks++; if (o_wr_strb !== 4'hF) begin errors++; $display("FAIL store_byte wr_strobe got=%b exp=1111", o_wr_strb); end
    checks++; if (o_wr_data !== e_wr_data) begin errors++; $display("FAIL store_byte wr_data got=%h exp=%h", o_wr_data, e_wr_data); end
`else
    checks++; if (o_wr_strb !== 4'b1000) begin errors++; $display("FAIL store_byte wr_strobe got=%b exp=1000", o_wr_strb); end
    checks++; if (o_wr_data !== 32'hA5A5_A5A5) begin errors++; $display("FAIL store_byte wr_data got=%h exp=a5a5a5a5", o_wr_data); end
    checks++; if (o_wr_cyc != 1 || o_rsp_cyc != 2) begin
      errors++; $display("FAIL store_byte timing got wr=%0d rsp=%0d exp wr=1 rsp=2", o_wr_cyc, o_rsp_cyc); end
    checks++; if (o_rdy_cyc != 3) begin errors++; $display("FAIL store_byte ready_cycle got=%0d exp=3", o_rdy_cyc); end
`endif
  endtask

  task automatic test_load_half();
    mem[8] = 32'h8001_1234; ref_mem[8] = 32'h8001_1234;
    predict(1'b0, 2'd1, 1'b1, 32'h22, 32'h0, 1);
    do_txn(1'b0, 2'd1, 1'b1, 32'h22, 32'h0, 1);
    checks++; if (o_rsp_rdata !== 32'hFFFF_8001) begin errors++; $display("FAIL load_half_s rdata got=%h exp=ffff8001", o_rsp_rdata); end
    checks++; if (o_rd_cyc != 1 || o_rsp_cyc != 3) begin
      errors++; $display("FAIL load_half_s timing got rd=%0d rsp=%0d exp rd=1 rsp=3", o_rd_cyc, o_rsp_cyc); end
    checks++; if (o_rd_addr !== 32'h8) begin errors++; $display("FAIL load_half_s rd_addr got=%h exp=8", o_rd_addr); end
    do_txn(1'b0, 2'd1, 1'b0, 32'h22, 32'h0, 1);
    checks++; if (o_rsp_rdata !== 32'h0000_8001) begin errors++; $display("FAIL load_half_u rdata got=%h exp=00008001", o_rsp_rdata); end
  endtask

  task automatic test_timeout();
    bit seen;
    predict(1'b0, 2'd2, 1'b0, 32'h404, 32'h0, 0);
    do_txn(1'b0, 2'd2, 1'b0, 32'h404, 32'h0, 0);
    checks++; if (o_rsp_err !== 1'b1 || o_rsp_rdata !== 32'h0) begin
      errors++; $display("FAIL timeout rsp got err=%b rdata=%h exp err=1 rdata=0", o_rsp_err, o_rsp_rdata); end
    checks++; if (o_rsp_cyc - o_rd_cyc != TMO + 2) begin
      errors++; $display("FAIL timeout latency got=%0d exp=%0d", o_rsp_cyc - o_rd_cyc, TMO + 2); end
    checks++; if (o_wr_cnt != 0) begin errors++; $display("FAIL timeout wr_count got=%0d exp=0", o_wr_cnt); end
    seen = 1'b0;
    @(negedge clk); slv_ready = 1'b1; slv_data = 32'hDEAD_BEEF;
    @(negedge clk); slv_ready = 1'b0;
    repeat (3) begin @(negedge clk); seen |= rsp_valid; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL late_ready rsp_valid got=1 exp=0"); end
    predict(1'b0, 2'd2, 1'b0, 32'h404, 32'h0, 2);
    do_txn(1'b0, 2'd2, 1'b0, 32'h404, 32'h0, 2);
    checks++; if (o_rsp_err !== 1'b0 || o_rsp_rdata !== e_rdata) begin
      errors++; $display("FAIL after_timeout got err=%b rdata=%h exp err=0 rdata=%h", o_rsp_err, o_rsp_rdata, e_rdata); end
    checks++; if (o_rsp_cyc != 4) begin errors++; $display("FAIL after_timeout rsp_cycle got=%0d exp=4", o_rsp_cyc); end
  endtask

  task automatic test_misaligned();
    do_txn(1'b0, 2'd2, 1'b0, 32'h6, 32'h0, 1);
    checks++; if (o_rsp_err !== 1'b1 || o_rsp_cyc != 1) begin
      errors++; $display("FAIL misaligned rsp got err=%b cyc=%0d exp err=1 cyc=1", o_rsp_err, o_rsp_cyc); end
    checks++; if (o_rd_cnt != 0 || o_wr_cnt != 0) begin
      errors++; $display("FAIL misaligned bus got rd=%0d wr=%0d exp 0/0", o_rd_cnt, o_wr_cnt); end
    checks++; if (o_rdy_cyc != 2) begin errors++; $display("FAIL misaligned ready_cycle got=%0d exp=2", o_rdy_cyc); end
  endtask

  task automatic test_reset_mid();
    bit seen;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_signed = 1'b0; req_addr = 32'h404;
    @(posedge clk);
    @(negedge clk); req_valid = 1'b0;
    checks++; if (mst_rd_valid !== 1'b1) begin errors++; $display("FAIL reset_mid rd_valid got=%b exp=1", mst_rd_valid); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if ({rsp_valid, rsp_err, mst_wr_valid, mst_rd_valid} !== 4'b0) begin
      errors++; $display("FAIL reset_mid pulses got=%b exp=0000", {rsp_valid, rsp_err, mst_wr_valid, mst_rd_valid}); end
    checks++; if ({rd_addr, wr_addr, wr_data, rsp_rdata, wr_strobe} !== 132'b0) begin
      errors++; $display("FAIL reset_mid buses got rd_addr=%h wr_addr=%h exp=0", rd_addr, wr_addr); end
    @(negedge clk); rst_n = 1'b1;
    seen = 1'b0;
    repeat (5) begin @(negedge clk); seen |= rsp_valid; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL reset_mid rsp_valid got=1 exp=0"); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_mid req_ready got=%b exp=1", req_ready); end
  endtask

`ifdef LSU_RMW_EN
  task automatic test_rmw();
    mem[12] = 32'h1122_3344; ref_mem[12] = 32'h1122_3344;
    predict(1'b1, 2'd1, 1'b0, 32'h32, 32'h0000_BEEF, 1);
    do_txn(1'b1, 2'd1, 1'b0, 32'h32, 32'h0000_BEEF, 1);
    checks++; if (o_rd_cnt != 1 || o_rd_addr !== 32'hC) begin
      errors++; $display("FAIL rmw read got cnt=%0d addr=%h exp 1/c", o_rd_cnt, o_rd_addr); end
    checks++; if (o_wr_data !== 32'hBEEF_3344 || o_wr_strb !== 4'hF) begin
      errors++; $display("FAIL rmw write got data=%h strb=%b exp beef3344/1111", o_wr_data, o_wr_strb); end
  endtask
`endif

  task automatic test_random();
    bit          we, sgn;
    logic [1:0]  sz;
    logic [31:0] addr, wd;
    int          lat;
    for (int n = 0; n < 80; n++) begin
      we   = 1'($urandom);
      sgn  = 1'($urandom);
      sz   = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      addr = 32'($urandom_range(0, 1023));
      if ($urandom_range(0, 2) != 0) addr[1:0] = (sz == 2'd2) ? 2'd0 : (sz == 2'd1) ? {addr[1], 1'b0} : addr[1:0];
      wd   = $urandom;
      lat  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 6);
      predict(we, sz, sgn, addr, wd, lat);
      do_txn(we, sz, sgn, addr, wd, lat);
      checks++; if (o_rsp_cnt != 1 || o_rsp_cyc != e_rsp_cyc) begin
        errors++; $display("FAIL rand[%0d] rsp got cnt=%0d cyc=%0d exp 1/%0d", n, o_rsp_cnt, o_rsp_cyc, e_rsp_cyc); end
      checks++; if (o_rsp_err !== e_err || o_rsp_rdata !== e_rdata) begin
        errors++; $display("FAIL rand[%0d] rsp got err=%b data=%h exp err=%b data=%h", n, o_rsp_err, o_rsp_rdata, e_err, e_rdata); end
      checks++; if (o_rd_cnt != e_rd_cnt || o_wr_cnt != e_wr_cnt) begin
        errors++; $display("FAIL rand[%0d] bus got rd=%0d wr=%0d exp rd=%0d wr=%0d", n, o_rd_cnt, o_wr_cnt, e_rd_cnt, e_wr_cnt); end
      checks++; if (o_rdy_cyc != e_rsp_cyc + 1) begin
        errors++; $display("FAIL rand[%0d] ready_cycle got=%0d exp=%0d", n, o_rdy_cyc, e_rsp_cyc + 1); end
      if (e_rd_cnt == 1) begin
        checks++; if (o_rd_addr !== {2'b00, addr[31:2]} || o_rd_cyc != 1) begin
          errors++; $display("FAIL rand[%0d] rd got addr=%h cyc=%0d exp addr=%h cyc=1", n, o_rd_addr, o_rd_cyc, addr >> 2); end
      end
      if (e_wr_cnt == 1) begin
        checks++; if (o_wr_addr !== {2'b00, addr[31:2]} || o_wr_cyc != e_wr_cyc) begin
          errors++; $display("FAIL rand[%0d] wr got addr=%h cyc=%0d exp addr=%h cyc=%0d", n, o_wr_addr, o_wr_cyc, addr >> 2, e_wr_cyc); end
        checks++; if (o_wr_data !== e_wr_data || o_wr_strb !== e_wr_strb) begin
          errors++; $display("FAIL rand[%0d] wr got data=%h strb=%b exp data=%h strb=%b", n, o_wr_data, o_wr_strb, e_wr_data, e_wr_strb); end
      end
    end
  endtask

  initial begin
    errors = 0; checks = 0;
    for (int i = 0; i < 256; i++) begin
      mem[i] = $urandom; ref_mem[i] = mem[i];
    end
    test_reset();
    test_store_byte();
    test_load_half();
    test_timeout();
    test_misaligned();
    test_reset_mid();
`ifdef LSU_RMW_EN
    test_rmw();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/lsu_bus_master.md
# lsu_bus_master

Load/store initiator on the ic0 data bus: accepts one core memory request at a time and drives the master side of the bus (`ic0_c_axi_mst_wr_valid`/`ic0_c_axi_mst_rd_valid`, addresses, data, strobes). It generates byte lanes, waits for the slave read response with a timeout, aligns and extends load data, and returns a single response to the core. It sits between the core pipeline and the data-memory slave. Unclaimed address regions time out instead of hanging.

## Interface
Parameters:
- `TIMEOUT`, 16: cycles to wait for `ic0_c_axi_slv_rd_ready_1` before flagging an error (≥2).

Ports:
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: core request present.
- `req_ready` out 1: block idle, request accepted when both high.
- `req_we` in 1: 1 store, 0 load.
- `req_size` in 2: 0 byte, 1 half, 2 word; 3 is illegal.
- `req_signed` in 1: sign-extend load result.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, LSB-justified.
- `rsp_valid` out 1: one-cycle response pulse.
- `rsp_rdata` out 32: aligned/extended load data, 0 for stores and errors.
- `rsp_err` out 1: misaligned, illegal size or timeout.
- `ic0_c_axi_mst_wr_valid` out 1: write pulse.
- `ic0_c_axi_mst_rd_valid` out 1: read pulse.
- `ic0_axi_mst_wr_addr` / `ic0_axi_mst_rd_addr` out 32: word address = `req_addr >> 2`.
- `ic0_axi_mst_wr_data` out 32, `ic0_axi_mst_wr_strobe` out 4.
- `ic0_c_axi_slv_rd_ready_1` in 1, `ic0_axi_slv_rd_data_1` in 32: slave read response.

## Operation
- All outputs are registered. Reset value of every output is 0, except `req_ready`, which is 1. The state resets to IDLE.
- States:
  - IDLE: accept a request.
    - Misaligned requests (half with `addr[0]`, word with `addr[1:0]`≠0) and size 3 go to RESP with `rsp_err`=1. No bus cycle is issued.
    - A store goes to WR.
    - A load goes to RD.
  - WR: one-cycle `mst_wr_valid`, then RESP. Writes are posted.
  - RD: one-cycle `mst_rd_valid`, then RD_WAIT.
  - RD_WAIT: counts cycles.
    - On `slv_rd_ready_1`, capture the data and go to RESP.
    - When the counter reaches `TIMEOUT`, go to RESP with `rsp_err`=1 and `rsp_rdata`=0.
  - RESP: pulse `rsp_valid` for one cycle, then return to IDLE.
- Store lanes:
  - byte: data `{4{wdata[7:0]}}`, strobe `4'b0001 << addr[1:0]`.
  - half: data `{2{wdata[15:0]}}`, strobe `4'b0011 << addr[1:0]`.
  - word: data `wdata`, strobe `4'hF`.
- Load extract: shift `rd_data` right by `addr[1:0]*8`, take 8/16/32 bits, then sign- or zero-extend per `req_signed`.
- Bus data/address/strobe outputs hold their values outside valid pulses. Only one transaction is outstanding.
- `slv_rd_ready_1` seen outside RD_WAIT is ignored, including a late response after a timeout.
- Reset mid-transaction abandons the transaction. No response is produced.

## Timing
- Request accepted at edge T.
- Store: `wr_valid` and `rsp_valid` are both visible during cycle T+1 (WR) and T+2 (RESP) respectively. `req_ready` returns high at T+3.
- Load:
  - `rd_valid` during T+1.
  - With a 1-cycle slave, ready arrives during T+2 and `rsp_valid` during T+3.
  - Load latency is 3 cycles.
- Timeout: `rsp_valid` with error is asserted `TIMEOUT`+2 cycles after `rd_valid`.
- Error without a bus cycle: `rsp_valid` during T+1.

## Configuration
- `LSU_RMW_EN` defined: sub-word stores are executed as read-modify-write.
  - Issue a read of the word (RD/RD_WAIT), then merge the new lanes into the returned word.
  - Write the merged word with strobe `4'hF` (extra state RMW_WR), then RESP.
  - If the RMW read times out, report `rsp_err`=1 and issue no write.
  - Required for slaves that zero unstrobed lanes.
- Undefined: sub-word stores issue a single strobed write, as described in Operation.

## Structure
- `lsu_pkg` holds:
  - `size_e` (BYTE/HALF/WORD)
  - the state enum `lsu_state_e`
  - `LSU_TIMEOUT_DEF`=16
  - the lane-mask constants
- Sub-module `lsu_lane_align` (combinational) contains:
  - strobe generation
  - write-data replication
  - load extract/extend
  - RMW merge

## Test plan
- Store byte, addr `0x103`, wdata `0xA5` → `wr_addr`=`0x40`, `wr_strobe`=`4'b1000`, `wr_data`=`0xA5A5A5A5`, `rsp_valid` at T+2, `rsp_err`=0.
- Load half signed, addr `0x22`; slave returns `0x8001_1234` one cycle after `rd_valid` → `rsp_rdata`=`0xFFFF8001` at T+3. The unsigned variant returns `0x00008001`.
- Load word, addr `0x404`, slave never responds (TIMEOUT=16) → `rsp_err`=1, `rsp_rdata`=0, 18 cycles after `rd_valid`. A late `slv_rd_ready_1` is ignored, and the next load completes normally.
- Word load at `0x6` → `rsp_err`=1 during T+1, no `rd_valid`/`wr_valid`.
- Assert `rst_n`=0 during RD_WAIT → all outputs 0 immediately, `req_ready`=1 after release, no `rsp_valid`.
- `LSU_RMW_EN`: memory word `0x11223344`, store half `0xBEEF` at offset 2 → read issued, then write of `0xBEEF3344` with strobe `4'hF`.
